// File: rtl/axis_frame_sched.sv
// axis_frame_sched: sequences frame triggers to an AXI-stream test master.
// Optional watchdog on a stalled frame is enabled by FRAME_TIMEOUT_EN.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   start           session start (sampled in IDLE only)
//   frame_cnt       frames per session, latched on start
//   gap_cycles      idle cycles after each eof beat, latched on start
//   abort           cancel the running session
//   s_vld, s_eof    master handshake, observed only
//   stream_trig     one-cycle trigger per frame
//   busy            high outside IDLE
//   done            one-cycle completion pulse
//   frames_sent     frames completed in current/last session
//   err_timeout     sticky watchdog flag (0 without FRAME_TIMEOUT_EN)
module axis_frame_sched #(
   parameter int CNT_WIDTH = 4,
   parameter int GAP_WIDTH = 8,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] frame_cnt,
   input  logic [GAP_WIDTH-1:0] gap_cycles,
   input  logic                 abort,
   input  logic                 s_vld,
   input  logic                 s_eof,
   output logic                 stream_trig,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] frames_sent,
   output logic                 err_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT,
      S_GAP,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_lat_q, cnt_lat_d;
   logic [CNT_WIDTH-1:0] sent_q, sent_d;
   logic [GAP_WIDTH-1:0] gap_lat_q, gap_lat_d;
   logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
   logic                 trig_q, trig_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 eof_beat;
   logic [CNT_WIDTH-1:0] sent_inc;

`ifdef FRAME_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
`endif

   assign eof_beat = s_vld & s_eof;
   assign sent_inc = sent_q + CNT_WIDTH'(1);

   always_comb begin
      state_d   = state_q;
      cnt_lat_d = cnt_lat_q;
      sent_d    = sent_q;
      gap_lat_d = gap_lat_q;
      gap_cnt_d = gap_cnt_q;
`ifdef FRAME_TIMEOUT_EN
      wd_d      = wd_q;
      err_d     = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               sent_d = '0;
               if (frame_cnt != '0) begin
                  cnt_lat_d = frame_cnt;
                  gap_lat_d = gap_cycles;
`ifdef FRAME_TIMEOUT_EN
                  err_d     = 1'b0;
`endif
                  state_d   = S_TRIG;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_TRIG: begin
`ifdef FRAME_TIMEOUT_EN
            wd_d    = '0;
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (eof_beat) begin
               sent_d = sent_inc;
               if (sent_inc == cnt_lat_q) begin
                  state_d = S_DONE;
               end else if (gap_lat_q == '0) begin
                  state_d = S_TRIG;
               end else begin
                  gap_cnt_d = gap_lat_q;
                  state_d   = S_GAP;
               end
            end
`ifdef FRAME_TIMEOUT_EN
            else if (wd_q == WD_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
`endif
         end
         S_GAP: begin
            // <= 1 keeps the counter from ever wrapping
            if (gap_cnt_q <= GAP_WIDTH'(1)) begin
               state_d = S_TRIG;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // abort wins over an eof beat or a timeout in the same cycle
      if (abort && state_q != S_IDLE) begin
         state_d   = S_IDLE;
         sent_d    = sent_q;
         gap_cnt_d = gap_cnt_q;
`ifdef FRAME_TIMEOUT_EN
         err_d     = err_q;
`endif
      end

      trig_d = (state_d == S_TRIG);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_lat_q <= '0;
         sent_q    <= '0;
         gap_lat_q <= '0;
         gap_cnt_q <= '0;
         trig_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
         wd_q      <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_lat_q <= cnt_lat_d;
         sent_q    <= sent_d;
         gap_lat_q <= gap_lat_d;
         gap_cnt_q <= gap_cnt_d;
         trig_q    <= trig_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef FRAME_TIMEOUT_EN
         wd_q      <= wd_d;
         err_q     <= err_d;
`endif
      end
   end

   assign stream_trig = trig_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign frames_sent = sent_q;
`ifdef FRAME_TIMEOUT_EN
   assign err_timeout = err_q;
`else
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_sched.sv
// tb_axis_frame_sched: scoreboard bench for axis_frame_sched.
// Expected trigger/done cycles are queued as stimulus is driven.
module tb_axis_frame_sched;

   localparam int CW = 4;
   localparam int GW = 8;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] frame_cnt = '0;
   logic [GW-1:0] gap_cycles = '0;
   logic          abort = 1'b0;
   logic          s_vld = 1'b0;
   logic          s_eof = 1'b0;
   logic          stream_trig;
   logic          busy;
   logic          done;
   logic [CW-1:0] frames_sent;
   logic          err_timeout;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int mon_e;
   int exp_trig[$];
   int exp_done[$];

   axis_frame_sched #(
      .CNT_WIDTH(CW),
      .GAP_WIDTH(GW),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .frame_cnt(frame_cnt),
      .gap_cycles(gap_cycles),
      .abort(abort),
      .s_vld(s_vld),
      .s_eof(s_eof),
      .stream_trig(stream_trig),
      .busy(busy),
      .done(done),
      .frames_sent(frames_sent),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // pop expected events as the DUT produces them
   always @(negedge clk) begin
      if (stream_trig === 1'b1) begin
         total++;
         if (exp_trig.size() == 0) begin
            bad++;
            $display("FAIL trig_unexp: trig at cycle %0d, none expected",
                     cyc);
         end else begin
            mon_e = exp_trig.pop_front();
            if (mon_e != cyc) begin
               bad++;
               $display("FAIL trig_cycle: got %0d want %0d", cyc, mon_e);
            end
         end
      end
      if (done === 1'b1) begin
         total++;
         if (exp_done.size() == 0) begin
            bad++;
            $display("FAIL done_unexp: done at cycle %0d, none expected",
                     cyc);
         end else begin
            mon_e = exp_done.pop_front();
            if (mon_e != cyc) begin
               bad++;
               $display("FAIL done_cycle: got %0d want %0d", cyc, mon_e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic drain(input string tag);
      total++;
      if (exp_trig.size() != 0 || exp_done.size() != 0) begin
         bad++;
         $display("FAIL %s_pending: trig=%0d done=%0d left, want 0",
                  tag, exp_trig.size(), exp_done.size());
         exp_trig.delete();
         exp_done.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ticks(2);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_busy: got %b want 0", busy);
      end
      total++;
      if (frames_sent !== '0) begin
         bad++;
         $display("FAIL rst_sent: got %0d want 0", frames_sent);
      end
      total++;
      if ({stream_trig, done, err_timeout} !== 3'b000) begin
         bad++;
         $display("FAIL rst_outs: got %b want 000",
                  {stream_trig, done, err_timeout});
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      frame_cnt  = 4'd3;
      gap_cycles = 8'd0;
      start      = 1'b1;
      exp_trig.push_back(cyc + 1);
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ticks(4);
         s_vld = 1'b1;
         s_eof = 1'b1;
         if (k < 2) exp_trig.push_back(cyc + 1);
         else       exp_done.push_back(cyc + 1);
         tick();
         s_vld = 1'b0;
         s_eof = 1'b0;
         total++;
         if (frames_sent !== CW'(k + 1)) begin
            bad++;
            $display("FAIL basic_sent%0d: got %0d want %0d",
                     k, frames_sent, k + 1);
         end
      end
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL basic_busy_done: got %b want 1", busy);
      end
      tick();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL basic_busy_end: got %b want 0", busy);
      end
      drain("basic");
   endtask

   task automatic test_gap();
      int e;
      frame_cnt  = 4'd2;
      gap_cycles = 8'd5;
      start      = 1'b1;
      exp_trig.push_back(cyc + 1);
      tick();
      start      = 1'b0;
      frame_cnt  = 4'd0;
      gap_cycles = 8'd0;
      tick();
      s_eof = 1'b1;
      tick();
      s_eof = 1'b0;
      total++;
      if (frames_sent !== 4'd0) begin
         bad++;
         $display("FAIL gap_bare_eof: got %0d want 0", frames_sent);
      end
      s_vld = 1'b1;
      s_eof = 1'b1;
      e = cyc;
      exp_trig.push_back(e + 6);
      tick();
      s_vld = 1'b0;
      s_eof = 1'b0;
      tick();
      s_vld = 1'b1;
      s_eof = 1'b1;
      tick();
      s_vld = 1'b0;
      s_eof = 1'b0;
      total++;
      if (frames_sent !== 4'd1) begin
         bad++;
         $display("FAIL gap_eof_in_gap: got %0d want 1", frames_sent);
      end
      ticks(5);
      s_vld = 1'b1;
      s_eof = 1'b1;
      exp_done.push_back(cyc + 1);
      tick();
      s_vld = 1'b0;
      s_eof = 1'b0;
      total++;
      if (frames_sent !== 4'd2) begin
         bad++;
         $display("FAIL gap_sent: got %0d want 2", frames_sent);
      end
      tick();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL gap_busy_end: got %b want 0", busy);
      end
      drain("gap");
   endtask

   task automatic test_zero();
      frame_cnt = 4'd0;
      start     = 1'b1;
      exp_done.push_back(cyc + 1);
      tick();
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || frames_sent !== 4'd0) begin
         bad++;
         $display("FAIL zero_state: busy=%b sent=%0d want busy=1 sent=0",
                  busy, frames_sent);
      end
      tick();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL zero_busy_end: got %b want 0", busy);
      end
      drain("zero");
   endtask

   task automatic test_abort();
      frame_cnt  = 4'd3;
      gap_cycles = 8'd0;
      start      = 1'b1;
      exp_trig.push_back(cyc + 1);
      tick();
      start = 1'b0;
      ticks(2);
      s_vld = 1'b1;
      s_eof = 1'b1;
      exp_trig.push_back(cyc + 1);
      tick();
      s_vld = 1'b0;
      s_eof = 1'b0;
      ticks(2);
      s_vld = 1'b1;
      s_eof = 1'b1;
      abort = 1'b1;
      tick();
      s_vld = 1'b0;
      s_eof = 1'b0;
      abort = 1'b0;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_busy: got %b want 0", busy);
      end
      total++;
      if (frames_sent !== 4'd1) begin
         bad++;
         $display("FAIL abort_sent: got %0d want 1", frames_sent);
      end
      ticks(3);
      drain("abort");
      // abort held in IDLE must not block a new start
      frame_cnt = 4'd1;
      start     = 1'b1;
      abort     = 1'b1;
      exp_trig.push_back(cyc + 1);
      tick();
      start = 1'b0;
      abort = 1'b0;
      total++;
      if (busy !== 1'b1 || frames_sent !== 4'd0) begin
         bad++;
         $display("FAIL restart: busy=%b sent=%0d want busy=1 sent=0",
                  busy, frames_sent);
      end
      ticks(2);
      s_vld = 1'b1;
      s_eof = 1'b1;
      exp_done.push_back(cyc + 1);
      tick();
      s_vld = 1'b0;
      s_eof = 1'b0;
      tick();
      total++;
      if (busy !== 1'b0 || frames_sent !== 4'd1) begin
         bad++;
         $display("FAIL restart_end: busy=%b sent=%0d want busy=0 sent=1",
                  busy, frames_sent);
      end
      drain("restart");
   endtask

   task automatic test_watchdog();
      frame_cnt = 4'd1;
      start     = 1'b1;
      exp_trig.push_back(cyc + 1);
      tick();
      start = 1'b0;
`ifdef FRAME_TIMEOUT_EN
      ticks(TO);
      total++;
      if (busy !== 1'b1 || err_timeout !== 1'b0) begin
         bad++;
         $display("FAIL wd_early: busy=%b err=%b want busy=1 err=0",
                  busy, err_timeout);
      end
      tick();
      total++;
      if (busy !== 1'b0 || err_timeout !== 1'b1) begin
         bad++;
         $display("FAIL wd_fire: busy=%b err=%b want busy=0 err=1",
                  busy, err_timeout);
      end
      ticks(3);
      total++;
      if (err_timeout !== 1'b1) begin
         bad++;
         $display("FAIL wd_sticky: got %b want 1", err_timeout);
      end
      start = 1'b1;
      exp_trig.push_back(cyc + 1);
      tick();
      start = 1'b0;
      total++;
      if (err_timeout !== 1'b0) begin
         bad++;
         $display("FAIL wd_clear: got %b want 0", err_timeout);
      end
      tick();
      s_vld = 1'b1;
      s_eof = 1'b1;
      exp_done.push_back(cyc + 1);
      tick();
      s_vld = 1'b0;
      s_eof = 1'b0;
      tick();
`else
      ticks(210);
      total++;
      if (busy !== 1'b1 || err_timeout !== 1'b0) begin
         bad++;
         $display("FAIL wd_off: busy=%b err=%b want busy=1 err=0",
                  busy, err_timeout);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
`endif
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL wd_end_busy: got %b want 0", busy);
      end
      drain("wd");
   endtask

   task automatic test_reset_mid();
      frame_cnt  = 4'd2;
      gap_cycles = 8'd5;
      start      = 1'b1;
      exp_trig.push_back(cyc + 1);
      tick();
      start = 1'b0;
      tick();
      s_vld = 1'b1;
      s_eof = 1'b1;
      tick();
      s_vld = 1'b0;
      s_eof = 1'b0;
      total++;
      if (frames_sent !== 4'd1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rmid_pre: sent=%0d busy=%b want sent=1 busy=1",
                  frames_sent, busy);
      end
      tick();
      rst = 1'b0;
      tick();
      total++;
      if ({stream_trig, busy, done, err_timeout} !== 4'b0000 ||
          frames_sent !== 4'd0) begin
         bad++;
         $display("FAIL rmid_outs: trig/busy/done/err=%b sent=%0d want 0",
                  {stream_trig, busy, done, err_timeout}, frames_sent);
      end
      rst = 1'b1;
      ticks(8);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL rmid_after: got busy=%b want 0", busy);
      end
      drain("rmid");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gap();
      test_zero();
      test_abort();
      test_watchdog();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_frame_sched.md
# axis_frame_sched

Frame scheduler that sequences the AXI-stream test master feeding the sorter. On a start command it issues a programmed number of one-cycle `stream_trig` pulses to the master, one per frame. Before each subsequent trigger it waits for the master's end-of-frame beat and then a programmable idle gap. It reports progress, completion and (optionally) a stalled-frame timeout to the bench or control logic.

## Interface

Parameters:
- `CNT_WIDTH`, 4: width of the frame count and progress counter.
- `GAP_WIDTH`, 8: width of the inter-frame gap counter.
- `TIMEOUT`, 64: watchdog limit in cycles spent in WAIT_EOF. Used only with `FRAME_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: clock. All logic is on the rising edge.
- `rst`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: session start. Sampled only in IDLE.
- `frame_cnt`, in, CNT_WIDTH: frames per session. Latched on an accepted `start`.
- `gap_cycles`, in, GAP_WIDTH: idle cycles between an eof beat and the next trigger. Latched on an accepted `start`.
- `abort`, in, 1: cancel the session.
- `s_vld`, in, 1: master valid, observed only.
- `s_eof`, in, 1: master end-of-frame, observed only.
- `stream_trig`, out, 1: one-cycle trigger to the master.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `frames_sent`, out, CNT_WIDTH: frames completed in the current or most recent session.
- `err_timeout`, out, 1: sticky watchdog flag.

## Operation

- States are IDLE, TRIG, WAIT_EOF, GAP and DONE. The FSM is Moore: `stream_trig` = (state==TRIG), `done` = (state==DONE), `busy` = (state!=IDLE).
- IDLE:
  - `start`=1 with `frame_cnt`≠0: latch `frame_cnt` and `gap_cycles`, clear `frames_sent`, clear `err_timeout`, go to TRIG.
  - `start`=1 with `frame_cnt`=0: clear `frames_sent`, go to DONE. No trigger is issued.
  - `start`=0: stay in IDLE.
- TRIG: go to WAIT_EOF unconditionally and clear the watchdog counter. `stream_trig` is high for exactly this one cycle.
- WAIT_EOF: on an eof beat (`s_vld`&`s_eof`), increment `frames_sent`. Then:
  - If the new count equals the latched `frame_cnt`, go to DONE.
  - Else if the latched gap is 0, go to TRIG.
  - Else load the gap counter with the latched gap and go to GAP.
- GAP: if the gap counter is 1, go to TRIG; otherwise decrement it.
- DONE: go to IDLE.
- Ignored inputs:
  - `s_eof` without `s_vld`.
  - Eof beats outside WAIT_EOF.
  - `start` outside IDLE.
- `abort`:
  - In any non-IDLE state, the next state is IDLE. No `done` pulse; `frames_sent` holds its value.
  - `abort` takes priority over an eof beat in the same cycle; that frame is not counted.
  - `abort` in IDLE has no effect.
- Arithmetic:
  - `frames_sent` compares against the latched `frame_cnt` at full CNT_WIDTH, so it never wraps within a session.
  - The gap counter is unsigned and never underflows.
- Reset: state goes to IDLE, counters and latches clear, and every output is 0. Reset mid-session drops the session silently with no `done`.

## Timing

- `start` sampled high at cycle t: `stream_trig` is high at t+1 and `busy` rises at t+1.
- Eof beat at cycle e:
  - With gap g>0: GAP occupies e+1..e+g and the next `stream_trig` is at e+g+1.
  - With g=0: the next `stream_trig` is at e+1.
- Last eof beat at cycle e: `done` is high at e+1 and `busy` falls at e+2.
- Zero-frame session with `start` at t: `done` is high at t+1.
- `abort` high at cycle a: `busy` falls at a+1.
- All outputs are registered state decodes, with no combinational path from inputs.

## Configuration

- Macro: `FRAME_TIMEOUT_EN`.
- Defined:
  - A watchdog counts cycles in WAIT_EOF.
  - When it reaches `TIMEOUT` with no eof beat, `err_timeout` is set and the FSM goes to IDLE with no `done`.
  - The flag stays set until the next accepted `start` or reset.
  - An eof beat in the same cycle the limit is reached wins: the frame is counted and no error is raised.
- Not defined: the watchdog logic is absent, `err_timeout` is tied to 0, and WAIT_EOF waits indefinitely.

## Test plan

- Basic session: reset, then `start` with `frame_cnt`=3, `gap_cycles`=0, and master eof 4 cycles after each trigger. Expect 3 `stream_trig` pulses, each 1 cycle after the preceding eof. Expect `frames_sent` 1→2→3, then `done` for one cycle and `busy` low.
- Gap check: `frame_cnt`=2, `gap_cycles`=5, eof at cycle e. Expect the second trigger at exactly e+6. Expect `s_eof` asserted with `s_vld`=0 to be ignored.
- Zero-frame session: `start` with `frame_cnt`=0. Expect `done` at t+1, no `stream_trig`, and `frames_sent`=0.
- Abort mid-session: `frame_cnt`=3, with `abort` in the same cycle as the second eof beat. Expect IDLE next cycle, `frames_sent`=1 and no `done`. Expect a following `start` to be accepted normally.
- Watchdog (`FRAME_TIMEOUT_EN` defined, `TIMEOUT`=64): trigger with no eof. Expect `err_timeout`=1 and `busy`=0 after 64 cycles in WAIT_EOF, and the flag cleared by the next `start`. Without the macro, `busy` stays high for over 200 cycles and `err_timeout`=0.
- Reset mid-session: drive `rst` low during GAP. Expect all outputs 0 on the next cycle and no `done`.
